// File: rtl/sincos_sched_pkg.sv
// Shared types and defaults for the two-requester sine/cosine scheduler.
package sincos_sched_pkg;

    localparam int SU_LAT_DEF  = 2;
    localparam int ANGLE_W_DEF = 16;
    localparam int N_REQ       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIN  = 2'd1,
        COS  = 2'd2
    } state_e;

    // One entry per sine-unit operation travelling through the unit's latency.
    typedef struct packed {
        logic valid;
        logic id;
        logic func;
    } tag_t;

endpackage

// File: rtl/sincos_rr_arb.sv
// Two-way round-robin arbiter; the registered pointer remembers the last winner.
module sincos_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = gnt_o[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sincos_sched.sv
// Shares one pipelined sine unit between two requesters, issuing sin then cos per request.
// Optional busy-cycle counter output enabled by defining SINCOS_SCHED_STATS_EN.
module sincos_sched
    import sincos_sched_pkg::*;
#(
    parameter int SU_LAT  = SU_LAT_DEF,
    parameter int ANGLE_W = ANGLE_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [2*ANGLE_W-1:0] req_angle,
    output logic [1:0]           req_ready,
    output logic [1:0]           res_valid,
    input  logic [1:0]           res_ready,
    output logic [2*ANGLE_W-1:0] res_sin,
    output logic [2*ANGLE_W-1:0] res_cos,
    output logic                 su_func,
    output logic [ANGLE_W-1:0]   su_x,
    input  logic [ANGLE_W-1:0]   su_value
`ifdef SINCOS_SCHED_STATS_EN
    ,
    output logic [15:0]          stat_busy_cnt
`endif
);

    state_e             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               id_q, id_d;
    tag_t               tag_q [SU_LAT];
    tag_t               tag_last;
    logic [N_REQ-1:0]   busy;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   gnt;
    logic               accept;

    assign eligible = req_valid & ~busy;
    assign accept   = |req_ready;
    assign tag_last = tag_q[SU_LAT-1];
    assign su_x     = angle_q;

    sincos_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (eligible),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        id_d      = id_q;
        req_ready = 2'b00;
        su_func   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    state_d = SIN;
                end
            end
            SIN: begin
                state_d = COS;
            end
            COS: begin
                su_func   = 1'b1;
                req_ready = gnt;
                state_d   = (|gnt) ? SIN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (|req_ready) begin
            angle_d = req_ready[1] ? req_angle[2*ANGLE_W-1:ANGLE_W] : req_angle[ANGLE_W-1:0];
            id_d    = req_ready[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            angle_q <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            id_q    <= id_d;
        end
    end

    // Stage 0 records the operation whose operand the sine unit samples this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SU_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: (state_q != IDLE), id: id_q, func: (state_q == COS)};
            for (int s = 1; s < SU_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic [ANGLE_W-1:0] sin_q;
        logic [ANGLE_W-1:0] cos_q;
        logic               rv_q;
        logic               pipe_hit;
        logic               capture;
        logic               last_hold;

        assign capture = tag_last.valid && (tag_last.id == 1'(gi));

        // A cosine landing this edge with the pop already requested frees the slot in time
        // for a new sine capture, which keeps two alternating requesters gap-free.
        assign last_hold = capture && !(tag_last.func && res_ready[gi]);

        always_comb begin
            pipe_hit = 1'b0;
            for (int s = 0; s < SU_LAT - 1; s++) begin
                if (tag_q[s].valid && (tag_q[s].id == 1'(gi))) begin
                    pipe_hit = 1'b1;
                end
            end
        end

        assign busy[gi] = rv_q | pipe_hit | last_hold
                        | ((state_q != IDLE) && (id_q == 1'(gi)));

        always_ff @(posedge clk) begin
            if (!reset) begin
                sin_q <= '0;
                cos_q <= '0;
                rv_q  <= 1'b0;
            end else begin
                if (capture && !tag_last.func) begin
                    sin_q <= su_value;
                end
                if (capture && tag_last.func) begin
                    cos_q <= su_value;
                    rv_q  <= 1'b1;
                end else if (rv_q && res_ready[gi]) begin
                    rv_q <= 1'b0;
                end
            end
        end

        assign res_sin[gi*ANGLE_W +: ANGLE_W] = sin_q;
        assign res_cos[gi*ANGLE_W +: ANGLE_W] = cos_q;
        assign res_valid[gi]                  = rv_q;
    end

`ifdef SINCOS_SCHED_STATS_EN
    logic [15:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if ((state_q != IDLE) && (busy_cnt_q != 16'hFFFF)) begin
            busy_cnt_d = busy_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_cnt_q <= 16'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign stat_busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_sincos_sched.sv
// Scoreboard bench for sincos_sched with a pipelined behavioural sine unit.
module tb_sincos_sched;

    localparam int SU_LAT = 2;
    localparam int W      = 16;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [2*W-1:0] req_angle;
    logic [1:0]    req_ready;
    logic [1:0]    res_valid;
    logic [1:0]    res_ready;
    logic [2*W-1:0] res_sin;
    logic [2*W-1:0] res_cos;
    logic          su_func;
    logic [W-1:0]  su_x;
    logic [W-1:0]  su_value;
`ifdef SINCOS_SCHED_STATS_EN
    logic [15:0]   stat_busy_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          acc_cyc [$];
    int          acc_id  [$];

    sincos_sched #(.SU_LAT(SU_LAT), .ANGLE_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sin   (res_sin),
        .res_cos   (res_cos),
        .su_func   (su_func),
        .su_x      (su_x),
        .su_value  (su_value)
`ifdef SINCOS_SCHED_STATS_EN
        ,
        .stat_busy_cnt (stat_busy_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic f, input logic [15:0] x);
        return f ? 16'(x * 16'd3 + 16'h1111) : (x ^ 16'hA5C3);
    endfunction

    // Behavioural sine unit: operand sampled at an edge, result captured SU_LAT edges later.
    logic [16:0] su_pipe [SU_LAT];
    always @(posedge clk) begin
        su_pipe[0] <= {su_func, su_x};
        for (int s = 1; s < SU_LAT; s++) su_pipe[s] <= su_pipe[s-1];
    end
    assign su_value = model(su_pipe[SU_LAT-1][16], su_pipe[SU_LAT-1][15:0]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [15:0] mon_ang;
    logic [31:0] mon_exp;
    logic [31:0] mon_got;
    always @(negedge clk) begin
        if (!reset) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_ang = req_angle[i*W +: W];
                    mon_exp = {model(1'b0, mon_ang), model(1'b1, mon_ang)};
                    if (i == 0) exp_q0.push_back(mon_exp);
                    else        exp_q1.push_back(mon_exp);
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(i);
                    $display("cyc %0d accept req%0d angle %h", cyc, i, mon_ang);
                end
                if (res_valid[i] && res_ready[i]) begin
                    mon_got = {res_sin[i*W +: W], res_cos[i*W +: W]};
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check_eq("sb_pending", 32'(i == 0 ? exp_q0.size() : exp_q1.size()), 32'd1);
                    end else begin
                        mon_exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check_eq("res_pair", mon_got, mon_exp);
                    end
                    $display("cyc %0d result req%0d sin %h cos %h", cyc, i,
                             mon_got[31:16], mon_got[15:0]);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_rv"},    32'(res_valid), 32'd0);
        check_eq({tag, "_func"},  32'(su_func),   32'd0);
        check_eq({tag, "_x"},     32'(su_x),      32'd0);
        check_eq({tag, "_sin"},   res_sin,        32'd0);
        check_eq({tag, "_cos"},   res_cos,        32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          k;
    int          lat;
    logic [1:0]  rv_seen;

    initial begin
        reset     = 1'b0;
        req_valid = 2'b00;
        req_angle = '0;
        res_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        tick();
        reset = 1'b1;

        // Single request from requester 0.
        req_angle = {16'h0000, 16'h2000};
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("t34_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("t34_x_sin",    32'(su_x),    32'h2000);
        check_eq("t34_func_sin", 32'(su_func), 32'd0);
        @(negedge clk);
        check_eq("t34_x_cos",    32'(su_x),    32'h2000);
        check_eq("t34_func_cos", 32'(su_func), 32'd1);
        for (k = 0; k < 20 && !res_valid[0]; k++) @(negedge clk);
        check_eq("t34_rv", 32'(res_valid[0]), 32'd1);
        lat = cyc - acc_cyc[acc_cyc.size()-1] - 1;
        check_eq("t34_latency", 32'(lat), 32'd4);
        check_eq("t34_sin", 32'(res_sin[15:0]), 32'(model(1'b0, 16'h2000)));
        check_eq("t34_cos", 32'(res_cos[15:0]), 32'(model(1'b1, 16'h2000)));
        tick();
        res_ready = 2'b01;
        tick();
        res_ready = 2'b00;
        @(negedge clk);
        check_eq("t34_popped", 32'(res_valid), 32'd0);

        // Reset right after the cosine issue of a request from requester 1.
        tick();
        req_angle = {16'h4321, 16'h0000};
        req_valid = 2'b10;
        @(negedge clk);
        check_eq("t37_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("t37");
        rv_seen = 2'b00;
        repeat (10) begin
            @(negedge clk);
            rv_seen = rv_seen | res_valid;
        end
        check_eq("t37_no_result", 32'(rv_seen), 32'd0);

        // Both requesters saturating the unit.
        tick();
        acc_cyc.delete();
        acc_id.delete();
        res_ready = 2'b11;
        req_valid = 2'b11;
        req_angle = {16'h1357, 16'h2468};
        repeat (16) begin
            tick();
            req_angle = {16'($urandom), 16'($urandom)};
        end
        req_valid = 2'b00;
        repeat (12) tick();
        check_eq("t35_count", 32'(acc_id.size()), 32'd8);
        if (acc_id.size() > 0) check_eq("t35_first", 32'(acc_id[0]), 32'd0);
        for (int i = 1; i < acc_id.size(); i++) begin
            check_eq("t35_alt", 32'(acc_id[i]), 32'(1 - acc_id[i-1]));
            check_eq("t35_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end

        // Requester 0 holds an unpopped result while requester 1 is served.
        res_ready = 2'b00;
        req_angle = {16'h1111, 16'h7777};
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("t36_ready0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        for (k = 0; k < 20 && !res_valid[0]; k++) @(negedge clk);
        check_eq("t36_rv0", 32'(res_valid[0]), 32'd1);
        tick();
        acc_cyc.delete();
        acc_id.delete();
        res_ready = 2'b10;
        req_valid = 2'b11;
        repeat (16) begin
            @(negedge clk);
            check_eq("t36_rdy0_low", 32'(req_ready[0]), 32'd0);
            check_eq("t36_hold", {res_sin[15:0], res_cos[15:0]},
                     {model(1'b0, 16'h7777), model(1'b1, 16'h7777)});
            tick();
            req_angle[31:16] = 16'($urandom);
        end
        check_eq("t36_served", 32'(acc_id.size() >= 3), 32'd1);
        for (int i = 0; i < acc_id.size(); i++) check_eq("t36_id", 32'(acc_id[i]), 32'd1);

        // Pop with requester 0 still requesting: eligible only after the pop edge.
        req_valid = 2'b01;
        req_angle[15:0] = 16'h0ABC;
        repeat (10) tick();
        res_ready = 2'b11;
        @(negedge clk);
        check_eq("t38_pre_ready", 32'(req_ready[0]), 32'd0);
        tick();
        res_ready = 2'b10;
        @(negedge clk);
        check_eq("t38_rv_clear",   32'(res_valid[0]), 32'd0);
        check_eq("t38_post_ready", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid = 2'b00;
        res_ready = 2'b11;
        repeat (12) tick();
        check_eq("sb_drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

`ifdef SINCOS_SCHED_STATS_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        acc_cyc.delete();
        acc_id.delete();
        req_valid = 2'b11;
        for (k = 0; k < 60; k++) begin
            tick();
            if (acc_id.size() >= 10) break;
        end
        req_valid = 2'b00;
        repeat (10) tick();
        check_eq("stat_count", 32'(stat_busy_cnt), 32'd20);
        force dut.busy_cnt_q = 16'hFFFF;
        tick();
        release dut.busy_cnt_q;
        req_valid = 2'b01;
        @(negedge clk);
        tick();
        req_valid = 2'b00;
        repeat (8) tick();
        check_eq("stat_sat", 32'(stat_busy_cnt), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sincos_sched.md
SINCOS_SCHED -- requirements
Module: sincos_sched

Interface
REQ-001 Parameter SU_LAT, 2: sine-unit latency in clock edges, from the operand-sampling edge to the result-capture edge.
REQ-002 Parameter ANGLE_W, 16: angle and result width, in the sine unit's 16-bit format.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 req_valid  in  2  per-requester request strobe.
REQ-006 req_angle  in  2*ANGLE_W  packed angles; requester i in bits [i*16 +: 16].
REQ-007 req_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-008 res_valid  out  2  per-requester sin/cos pair available.
REQ-009 res_ready  in  2  per-requester result pop.
REQ-010 res_sin, res_cos  out  2*ANGLE_W each  packed results, same slicing as req_angle.
REQ-011 su_func  out  1  sine-unit function select: 0 = sine, 1 = cosine.
REQ-012 su_x  out  ANGLE_W  sine-unit operand.
REQ-013 su_value  in  ANGLE_W  sine-unit result.

Function
REQ-014 The block SHALL share one sine unit between 2 requesters, issuing one sine and one cosine of the same angle per accepted request.
REQ-015 The FSM SHALL have three states, IDLE, SIN and COS:
- IDLE→SIN on accept.
- SIN→COS unconditionally.
- COS→SIN on accept, otherwise COS→IDLE.
REQ-016 Requester i SHALL be eligible when req_valid[i] is high and busy[i] is low. busy[i] = res_valid[i] OR an operation for i is in flight.
REQ-017 Arbitration SHALL run only in IDLE or COS. req_ready SHALL be 0 in SIN.
REQ-018 Arbitration SHALL be round-robin. With both requesters eligible, the grant goes to the one not granted last. After reset the last-granted pointer is 1, so requester 0 wins first.
REQ-019 req_ready SHALL be one-hot or zero, and combinational from the registered state and req_valid.
REQ-020 On accept, the block SHALL latch the angle and requester id.
REQ-021 Sine-unit drive by state:
- SIN: su_x = latched angle, su_func = 0.
- COS: su_x = latched angle, su_func = 1.
- IDLE: su_x holds its value, su_func = 0.
REQ-022 A tag pipeline of depth SU_LAT SHALL carry {valid, id, func}. At the capture edge, su_value SHALL be written to the sin or cos slot of buffer[id].
REQ-023 res_valid[id] SHALL set at the cosine capture edge. It SHALL clear on the edge where res_ready[id] is sampled high.
REQ-024 Timing with accept at edge A and SU_LAT=2:
- Sine operand sampled at A+1, cosine operand at A+2.
- res_valid high after A+4.
- Sustained throughput: one request per 2 cycles.
REQ-025 res_sin/res_cos SHALL hold stable while res_valid is high.
REQ-026 A pop at edge k SHALL make the requester eligible from cycle k+1; there is no same-cycle pop-and-accept.
REQ-027 res_ready on a slot whose res_valid is low SHALL have no effect.

Reset
REQ-028 While reset=0 the block SHALL clear, at the next edge:
- state to IDLE;
- the tag pipeline;
- res_valid, req_ready, su_func, su_x, res_sin and res_cos to 0;
- the round-robin pointer to 1.
REQ-029 Reset mid-operation SHALL discard in-flight operations; no res_valid may result from them.

Configuration
REQ-030 With SINCOS_SCHED_STATS_EN defined, output stat_busy_cnt (16 bits) SHALL count cycles with state ≠ IDLE. It saturates at 16'hFFFF and clears on reset.
REQ-031 Without SINCOS_SCHED_STATS_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-032 Package sincos_sched_pkg SHALL hold:
- the state enum {IDLE, SIN, COS};
- the tag struct {valid, id, func};
- the SU_LAT default constant.
REQ-033 Round-robin arbitration SHALL be a sub-module, sincos_rr_arb (2-way, registered pointer).

Verification
REQ-034 Single request, angle 16'h2000 from requester 0:
- req_ready[0]=1 in the request cycle.
- su_x=16'h2000 with su_func 0 then 1 on consecutive cycles.
- res_valid[0] rises 4 edges after accept, with the values captured from the bench sine model.
REQ-035 Both req_valid held high, res_ready=2'b11: grants alternate 0,1,0,1, one accept every 2 cycles, no idle cycles.
REQ-036 res_ready[0]=0 with res_valid[0]=1: req_ready[0] stays 0 while requester 1 is served back-to-back; result 0 stays stable.
REQ-037 reset=0 for one cycle right after the COS issue: all outputs 0 next cycle; no res_valid appears for the lost request.
REQ-038 Pop at edge k with req_valid[0] still high: req_ready[0]=1 in cycle k+1, not earlier.
REQ-039 With SINCOS_SCHED_STATS_EN: 10 back-to-back requests → stat_busy_cnt = 20; forced 16'hFFFF → stays 16'hFFFF.
